// File: rtl/qspi_pkg.sv
// Shared types and constants for the quad-SPI host controller.
package qspi_pkg;

    localparam logic [7:0] QSPI_OP_READ  = 8'h6B;
    localparam logic [7:0] QSPI_OP_WRITE = 8'h32;
    localparam logic [7:0] QSPI_OP_ERASE = 8'h20;

    typedef enum logic [1:0] {
        OpRead    = 2'b00,
        OpWrite   = 2'b01,
        OpErase   = 2'b10,
        OpIllegal = 2'b11
    } cmd_op_e;

    typedef enum logic [3:0] {
        StIdle,
        StCmd,
        StAddr,
        StWdata,
        StDummy,
        StRdata,
        StHold,
        StGap,
        StResp
    } state_e;

    function automatic logic [7:0] op_opcode(input cmd_op_e op);
        case (op)
            OpRead:  return QSPI_OP_READ;
            OpWrite: return QSPI_OP_WRITE;
            default: return QSPI_OP_ERASE;
        endcase
    endfunction

endpackage

// File: rtl/qspi_host_ctrl_if.sv
// System-side command/response bus of the quad-SPI host controller.
interface qspi_host_ctrl_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_addr;
    logic [3:0] cmd_wdata;
    logic       rsp_valid;
    logic [3:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

endinterface

// File: rtl/qspi_sck_gen.sv
// Serial clock generator: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
// rise_o/fall_o are high in the cycle whose closing edge flips the serial clock.
module qspi_sck_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic clear_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CntW = $clog2(CLK_DIV + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sck_q, sck_d;
    logic            tc;

    assign tc     = en_i && (cnt_q == CntW'(CLK_DIV - 1));
    assign rise_o = tc && !sck_q;
    assign fall_o = tc && sck_q;
    assign sck_o  = sck_q;

    always_comb begin
        cnt_d = cnt_q;
        sck_d = sck_q;
        if (!en_i || clear_i) begin
            cnt_d = '0;
            sck_d = 1'b0;
        end else if (tc) begin
            cnt_d = '0;
            sck_d = !sck_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

endmodule

// File: rtl/qspi_host_ctrl.sv
// Quad-SPI host: serialises read/write/erase commands as quad nibbles and
// returns a one-cycle response pulse when chip select is released.
module qspi_host_ctrl
    import qspi_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned DUMMY_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    qspi_host_ctrl_if.slave        bus,
    output logic                   QSPI_CLK,
    output logic                   QSPI_CS_b,
    output logic                   QSPI_RST_b,
    output logic [3:0]             qspi_io_out,
    output logic                   qspi_io_oe,
    input  logic [3:0]             qspi_io_in
);

    localparam int unsigned GapW         = $clog2(2 * CLK_DIV);
    localparam logic [3:0]  LastCmdNib   = 4'd1;
    localparam logic [3:0]  LastAddrNib  = 4'd3;
    localparam logic [3:0]  LastDummyNib = 4'(3 + DUMMY_CYCLES);

    state_e          state_q, state_d;
    cmd_op_e         op_q;
    logic [7:0]      addr_q;
    logic [3:0]      wdata_q;
    logic [3:0]      nib_q;
    logic [GapW-1:0] gap_q;
    logic [3:0]      rd_sample_q;
    logic [3:0]      rsp_rdata_q;
    logic            rsp_valid_q, rsp_err_q, rst_b_q;
    logic            accept, accept_ill, frame_done;
    logic            sck_en, sck_rise, sck_fall;
    logic [7:0]      opcode;

    assign accept     = bus.cmd_valid && (state_q == StIdle);
    assign accept_ill = accept && (cmd_op_e'(bus.cmd_op) == OpIllegal);
    // Hold ends on the would-be rising edge; the divider is cleared instead.
    assign frame_done = (state_q == StHold) && sck_rise;
    assign opcode     = op_opcode(op_q);

    qspi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk_i   (clk),
        .reset_i (reset),
        .en_i    (sck_en),
        .clear_i (frame_done),
        .sck_o   (QSPI_CLK),
        .rise_o  (sck_rise),
        .fall_o  (sck_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = accept_ill ? StResp : StCmd;
            StCmd:   if (sck_fall && nib_q == LastCmdNib) state_d = StAddr;
            StAddr: begin
                if (sck_fall && nib_q == LastAddrNib) begin
                    case (op_q)
                        OpWrite: state_d = StWdata;
                        OpErase: state_d = StHold;
                        default: state_d = (DUMMY_CYCLES == 0) ? StRdata : StDummy;
                    endcase
                end
            end
            StDummy: if (sck_fall && nib_q == LastDummyNib) state_d = StRdata;
            StWdata: if (sck_fall) state_d = StHold;
            StRdata: if (sck_fall) state_d = StHold;
            StHold:  if (sck_rise) state_d = StGap;
            StGap:   if (gap_q == GapW'(2 * CLK_DIV - 1)) state_d = StIdle;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sck_en      = 1'b0;
        qspi_io_oe  = 1'b0;
        qspi_io_out = 4'h0;
        unique case (state_q)
            StCmd: begin
                sck_en      = 1'b1;
                qspi_io_oe  = 1'b1;
                qspi_io_out = nib_q[0] ? opcode[3:0] : opcode[7:4];
            end
            StAddr: begin
                sck_en      = 1'b1;
                qspi_io_oe  = 1'b1;
                qspi_io_out = nib_q[0] ? addr_q[3:0] : addr_q[7:4];
            end
            StWdata: begin
                sck_en      = 1'b1;
                qspi_io_oe  = 1'b1;
                qspi_io_out = wdata_q;
            end
            StDummy, StRdata, StHold: sck_en = 1'b1;
            default: ;
        endcase
    end

    assign QSPI_CS_b     = !sck_en;
    assign QSPI_RST_b    = rst_b_q;
    assign bus.cmd_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    always_ff @(posedge clk) begin
        rst_b_q <= !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OpRead;
            addr_q      <= 8'h00;
            wdata_q     <= 4'h0;
            nib_q       <= 4'h0;
            gap_q       <= '0;
            rd_sample_q <= 4'h0;
            rsp_rdata_q <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                op_q    <= cmd_op_e'(bus.cmd_op);
                addr_q  <= bus.cmd_addr;
                wdata_q <= bus.cmd_wdata;
            end
            if (state_q == StIdle) nib_q <= 4'h0;
            else if (sck_fall)     nib_q <= nib_q + 4'd1;
            gap_q <= (state_q == StGap) ? gap_q + GapW'(1) : '0;
            if (state_q == StRdata && sck_rise) rd_sample_q <= qspi_io_in;
            if (frame_done && op_q == OpRead)   rsp_rdata_q <= rd_sample_q;
            rsp_valid_q <= frame_done || accept_ill;
            rsp_err_q   <= accept_ill;
        end
    end

endmodule

// File: tb/tb_qspi_host_ctrl.sv
// Self-checking bench: directed and random commands against a cycle-offset frame model.
module tb_qspi_host_ctrl;

    localparam int unsigned D  = 2;
    localparam int unsigned DC = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       sck, cs_b, rst_b, oe;
    logic [3:0] io_out;
    logic [3:0] io_in = 4'h0;

    qspi_host_ctrl_if bus ();

    qspi_host_ctrl #(
        .CLK_DIV      (D),
        .DUMMY_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .QSPI_CLK    (sck),
        .QSPI_CS_b   (cs_b),
        .QSPI_RST_b  (rst_b),
        .qspi_io_out (io_out),
        .qspi_io_oe  (oe),
        .qspi_io_in  (io_in)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] last_rd  = 4'h0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] opcode_of(input logic [1:0] op);
        case (op)
            2'b00:   return 8'h6B;
            2'b01:   return 8'h32;
            default: return 8'h20;
        endcase
    endfunction

    // Called at a negedge; offers the command, then checks every cycle up to cmd_ready.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr, input logic [3:0] wdata,
                           input logic [3:0] rdata, input bit keep_valid,
                           input logic [7:0] nxt_addr, input logic [3:0] nxt_wdata,
                           output int unsigned t_start, output int unsigned t_rsp);
        int         w, n_nib, n_out, fe, rsp_j, rdy_j, idx;
        logic [7:0] opc;
        logic [3:0] nibs[5];
        bit         exp_cs, exp_sck, exp_oe;
        t_start = 0;
        t_rsp   = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        w = 0;
        while (!bus.cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept_wait", 32'(w < 200), 32'd1);
        opc  = opcode_of(op);
        nibs = '{opc[7:4], opc[3:0], addr[7:4], addr[3:0], wdata};
        case (op)
            2'b00:   begin n_nib = 5 + DC; n_out = 4; end
            2'b01:   begin n_nib = 5;      n_out = 5; end
            2'b10:   begin n_nib = 4;      n_out = 4; end
            default: begin n_nib = 0;      n_out = 0; end
        endcase
        fe    = 2 * D * n_nib;
        rsp_j = (op == 2'b11) ? 1 : fe + D + 1;
        rdy_j = rsp_j + ((op == 2'b11) ? 1 : 2 * D);
        for (int j = 1; j <= rdy_j; j++) begin
            @(negedge clk);
            if (j == 1) begin
                t_start = cyc;
                if (keep_valid) begin
                    bus.cmd_addr  = nxt_addr;
                    bus.cmd_wdata = nxt_wdata;
                end else begin
                    bus.cmd_valid = 1'b0;
                end
            end
            idx     = (j - 1) / (2 * D);
            exp_cs  = (op == 2'b11) || (j > fe + D);
            exp_sck = (j <= fe) && (((j - 1) % (2 * D)) >= D);
            exp_oe  = (j <= fe) && (idx < n_out);
            io_in   = (op == 2'b00 && j <= fe && idx == n_nib - 1) ? rdata : ~rdata;
            check_eq("cs_b", cs_b, exp_cs);
            check_eq("sck", sck, exp_sck);
            check_eq("oe", oe, exp_oe);
            if (exp_oe) check_eq("io_nibble", io_out, nibs[idx]);
            check_eq("rsp_valid", bus.rsp_valid, 32'(j == rsp_j));
            check_eq("cmd_ready", bus.cmd_ready, 32'(j == rdy_j));
            check_eq("busy", bus.busy, 32'(j != rdy_j));
            if (j == rsp_j) begin
                t_rsp = cyc;
                if (op == 2'b00) last_rd = rdata;
                check_eq("rsp_err", bus.rsp_err, 32'(op == 2'b11));
                check_eq("rsp_rdata", bus.rsp_rdata, last_rd);
            end
        end
    endtask

    initial begin
        int unsigned ts1, tr1, ts2, tr2;
        int          bad_rsp;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 4'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_cs_b", cs_b, 1);
        check_eq("rst_sck", sck, 0);
        check_eq("rst_oe", oe, 0);
        check_eq("rst_io", io_out, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_rsp_err", bus.rsp_err, 0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata, 0);
        check_eq("rst_qspi_rst_b", rst_b, 0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", bus.cmd_ready, 1);
        check_eq("post_rst_qspi_rst_b", rst_b, 1);

        run_cmd(2'b01, 8'h00, 4'hA, 4'h0, 1'b0, 8'h00, 4'h0, ts1, tr1);
        check_eq("write_rsp_latency", tr1 - ts1, 22);
        run_cmd(2'b00, 8'h00, 4'h0, 4'hA, 1'b0, 8'h00, 4'h0, ts1, tr1);
        check_eq("read_rsp_latency", tr1 - ts1, 30);
        run_cmd(2'b10, 8'h5C, 4'h0, 4'h0, 1'b0, 8'h00, 4'h0, ts1, tr1);
        check_eq("erase_rsp_latency", tr1 - ts1, 18);
        run_cmd(2'b11, 8'hFF, 4'hF, 4'h0, 1'b0, 8'h00, 4'h0, ts1, tr1);

        // Two queued writes with cmd_valid never dropped between them.
        run_cmd(2'b01, 8'h11, 4'h1, 4'h0, 1'b1, 8'h22, 4'h2, ts1, tr1);
        run_cmd(2'b01, 8'h22, 4'h2, 4'h0, 1'b0, 8'h00, 4'h0, ts2, tr2);
        check_eq("b2b_spacing", ts2 - tr1, 2 * D + 1);

        // Reset during the address phase of a write.
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b01;
        bus.cmd_addr  = 8'h3C;
        bus.cmd_wdata = 4'h5;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (9) @(negedge clk);
        check_eq("pre_rst_oe", oe, 1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("midrst_cs_b", cs_b, 1);
        check_eq("midrst_sck", sck, 0);
        check_eq("midrst_oe", oe, 0);
        check_eq("midrst_rsp_valid", bus.rsp_valid, 0);
        check_eq("midrst_ready", bus.cmd_ready, 1);
        check_eq("midrst_qspi_rst_b", rst_b, 0);
        reset   = 1'b0;
        last_rd = 4'h0;
        bad_rsp = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.rsp_valid || !cs_b) bad_rsp++;
        end
        check_eq("midrst_no_rsp", bad_rsp, 0);
        run_cmd(2'b00, 8'h81, 4'h0, 4'h6, 1'b0, 8'h00, 4'h0, ts1, tr1);

        for (int i = 0; i < 24; i++) begin
            run_cmd(2'($urandom_range(0, 3)), 8'($urandom), 4'($urandom), 4'($urandom),
                    1'b0, 8'h00, 4'h0, ts1, tr1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
